ahb_uart_pro: RTL and testbench

AHB-Lite slave UART: a parametrised successor to the fixed-format AHB UART. It adds a programmable 16-bit baud divisor with 16x RX oversampling, parametrised data width and FIFO depth, and sticky error flags. It also provides masked interrupt sources, internal loopback and zero-wait-state bus access with no bus stall. It sits on the AHB-Lite peripheral bus beside the existing peripherals and drives one RS-232 pin pair.

---
 rtl/ahb_uart_pro_if.sv | 13 +
 rtl/ahb_uart_pro.sv | 261 ++++++++++++++++++++++++++
 tb/tb_ahb_uart_pro.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ahb_uart_pro_if.sv
// ahb_uart_pro_if: AHB-Lite bus bundle between a master and the ahb_uart_pro slave
interface ahb_uart_pro_if;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic        HREADY;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        HREADYOUT;
   modport master (output HSEL, HADDR, HTRANS, HWRITE, HREADY, HWDATA, input HRDATA, HREADYOUT);
   modport slave (input HSEL, HADDR, HTRANS, HWRITE, HREADY, HWDATA, output HRDATA, HREADYOUT);
endinterface

// File: rtl/ahb_uart_pro.sv
// ahb_uart_pro: AHB-Lite UART with 16-bit baud divisor, 16x RX oversampling, FIFOs, sticky errors and IRQs.
// Parity framing, CTRL[3:2] and parity_err exist only when UART_PARITY_EN is defined.
module ahb_uart_pro #(
   parameter int FIFO_AW = 4,
   parameter int DATA_BITS = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd325
) (
   input  logic HCLK,
   input  logic HRESET,
   ahb_uart_pro_if.slave bus,
   input  logic RsRx,
   output logic RsTx,
   output logic uart_irq
);
   localparam int PW = FIFO_AW + 1;
`ifdef UART_PARITY_EN
   localparam logic [4:0] CTRL_MASK = 5'h1f;
`else
   localparam logic [4:0] CTRL_MASK = 5'h13;
`endif
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;
   logic a_valid, a_write;
   logic [2:0] a_addr;
   logic [4:0] ctrl;
   logic [15:0] bauddiv, tcnt;
   logic [2:0] irq_en;
   logic tick, wr, rd;
   logic [3:0] w1c;
   logic rx_ovr, frame_err, parity_err, tx_ovf;
   logic [DATA_BITS-1:0] tx_mem [1 << FIFO_AW];
   logic [DATA_BITS-1:0] rx_mem [1 << FIFO_AW];
   logic [PW-1:0] tx_wp, tx_rp, rx_wp, rx_rp, tx_lvl, rx_lvl;
   logic tx_empty, tx_full, rx_empty, rx_full;
   logic tx_push, tx_pop, tx_push_ok, rx_push, rx_pop, rx_push_ok;
   logic [DATA_BITS-1:0] tx_head, rx_head, rx_rdata;
   state_t tx_st, rx_st;
   logic [3:0] tx_cnt, rx_cnt;
   logic [2:0] tx_idx, rx_idx;
   logic [DATA_BITS-1:0] tx_sh, rx_sh;
   logic txd, s1, s2, rx_prev, rx_in, rx_ferr, rx_perr;
`ifdef UART_PARITY_EN
   logic tx_par, tx_pon, rx_par;
`endif
   logic [31:0] status;
   logic unused_bits;
   assign unused_bits = ^{bus.HADDR[31:5], bus.HADDR[1:0], bus.HTRANS[0], bus.HWDATA[31:16]};
   assign wr = a_valid & a_write & bus.HREADY;
   assign rd = a_valid & ~a_write & bus.HREADY;
   assign w1c = wr && a_addr == 3'd1 ? bus.HWDATA[8:5] : 4'd0;
   assign tick = tcnt == bauddiv;
   assign tx_lvl = tx_wp - tx_rp;
   assign rx_lvl = rx_wp - rx_rp;
   assign tx_empty = tx_lvl == '0;
   assign rx_empty = rx_lvl == '0;
   assign tx_full = tx_lvl[FIFO_AW];
   assign rx_full = rx_lvl[FIFO_AW];
   assign tx_head = tx_mem[tx_rp[FIFO_AW-1:0]];
   assign rx_head = rx_mem[rx_rp[FIFO_AW-1:0]];
   assign rx_rdata = rx_empty ? '0 : rx_head;
   assign tx_push = wr && a_addr == 3'd0;
   assign tx_pop = tx_st == IDLE && tick && ctrl[0] && !tx_empty;
   assign tx_push_ok = tx_push & (~tx_full | tx_pop);
   assign rx_pop = rd && a_addr == 3'd0 && !rx_empty;
   assign rx_push_ok = rx_push & (~rx_full | rx_pop);
   assign rx_in = ctrl[4] ? txd : s2;
   assign RsTx = txd | ctrl[4];
   assign status = {8'(tx_lvl), 8'(rx_lvl), 7'd0, tx_ovf, parity_err, frame_err, rx_ovr,
                    tx_st != IDLE, tx_full, tx_empty, rx_full, rx_empty};
   assign bus.HREADYOUT = 1'b1;
   assign bus.HRDATA = !(a_valid && !a_write) ? 32'd0 :
                       a_addr == 3'd0 ? 32'(rx_rdata) :
                       a_addr == 3'd1 ? status :
                       a_addr == 3'd2 ? {27'd0, ctrl} :
                       a_addr == 3'd3 ? {16'd0, bauddiv} :
                       a_addr == 3'd4 ? {29'd0, irq_en} : 32'd0;
   // Latch the address phase whenever the bus is ready
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         a_valid <= 1'b0;
         a_write <= 1'b0;
         a_addr <= 3'd0;
      end else if (bus.HREADY) begin
         a_valid <= bus.HSEL & bus.HTRANS[1];
         a_write <= bus.HWRITE;
         a_addr <= bus.HADDR[4:2];
      end
   end
   // Control registers, oversample tick, sticky flags and interrupt output
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         ctrl <= 5'd0;
         bauddiv <= DEFAULT_DIV;
         irq_en <= 3'd0;
         tcnt <= 16'd0;
         rx_ovr <= 1'b0;
         frame_err <= 1'b0;
         parity_err <= 1'b0;
         tx_ovf <= 1'b0;
         uart_irq <= 1'b0;
      end else begin
         if (wr && a_addr == 3'd2) ctrl <= bus.HWDATA[4:0] & CTRL_MASK;
         if (wr && a_addr == 3'd3) bauddiv <= bus.HWDATA[15:0];
         if (wr && a_addr == 3'd4) irq_en <= bus.HWDATA[2:0];
         tcnt <= (wr && a_addr == 3'd3) || tick ? 16'd0 : tcnt + 16'd1;
         rx_ovr <= (rx_push & ~rx_push_ok) | (rx_ovr & ~w1c[0]);
         frame_err <= rx_ferr | (frame_err & ~w1c[1]);
         parity_err <= rx_perr | (parity_err & ~w1c[2]);
         tx_ovf <= (tx_push & ~tx_push_ok) | (tx_ovf & ~w1c[3]);
         uart_irq <= |(irq_en & {rx_ovr | frame_err | parity_err | tx_ovf, tx_empty, ~rx_empty});
      end
   end
   // FIFO pointers; a push into a full FIFO succeeds only alongside a pop
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         tx_wp <= '0;
         tx_rp <= '0;
         rx_wp <= '0;
         rx_rp <= '0;
      end else begin
         tx_wp <= tx_wp + {{FIFO_AW{1'b0}}, tx_push_ok};
         tx_rp <= tx_rp + {{FIFO_AW{1'b0}}, tx_pop};
         rx_wp <= rx_wp + {{FIFO_AW{1'b0}}, rx_push_ok};
         rx_rp <= rx_rp + {{FIFO_AW{1'b0}}, rx_pop};
      end
   end
   // FIFO storage, no reset needed
   always_ff @(posedge HCLK) begin
      if (tx_push_ok) tx_mem[tx_wp[FIFO_AW-1:0]] <= bus.HWDATA[DATA_BITS-1:0];
      if (rx_push_ok) rx_mem[rx_wp[FIFO_AW-1:0]] <= rx_sh;
   end
   // Transmitter: one bit per 16 ticks, new frames only start from IDLE with tx_en set
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         tx_st <= IDLE;
         tx_cnt <= 4'd0;
         tx_idx <= 3'd0;
         tx_sh <= '0;
         txd <= 1'b1;
`ifdef UART_PARITY_EN
         tx_par <= 1'b0;
         tx_pon <= 1'b0;
`endif
      end else if (tick) begin
         tx_cnt <= tx_st == IDLE ? 4'd0 : tx_cnt + 4'd1;
         case (tx_st)
            IDLE: if (tx_pop) begin
               tx_st <= START;
               tx_sh <= tx_head;
               txd <= 1'b0;
`ifdef UART_PARITY_EN
               tx_par <= ^tx_head ^ ctrl[2];
               tx_pon <= ctrl[3];
`endif
            end
            START: if (tx_cnt == 4'd15) begin
               tx_st <= DATA;
               tx_idx <= 3'd0;
               txd <= tx_sh[0];
               tx_sh <= tx_sh >> 1;
            end
            DATA: if (tx_cnt == 4'd15) begin
               if (tx_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                  tx_st <= tx_pon ? PARITY : STOP;
                  txd <= tx_pon ? tx_par : 1'b1;
`else
                  tx_st <= STOP;
                  txd <= 1'b1;
`endif
               end else begin
                  tx_idx <= tx_idx + 3'd1;
                  txd <= tx_sh[0];
                  tx_sh <= tx_sh >> 1;
               end
            end
`ifdef UART_PARITY_EN
            PARITY: if (tx_cnt == 4'd15) begin
               tx_st <= STOP;
               txd <= 1'b1;
            end
`endif
            STOP: if (tx_cnt == 4'd15) tx_st <= IDLE;
            default: tx_st <= IDLE;
         endcase
      end
   end
   // Receiver: synchronise, detect start edge, sample mid-bit, push at the stop bit
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
         rx_prev <= 1'b1;
         rx_st <= IDLE;
         rx_cnt <= 4'd0;
         rx_idx <= 3'd0;
         rx_sh <= '0;
         rx_push <= 1'b0;
         rx_ferr <= 1'b0;
         rx_perr <= 1'b0;
`ifdef UART_PARITY_EN
         rx_par <= 1'b0;
`endif
      end else begin
         s1 <= RsRx;
         s2 <= s1;
         rx_prev <= rx_in;
         rx_push <= 1'b0;
         rx_ferr <= 1'b0;
         rx_perr <= 1'b0;
         if (!ctrl[1]) rx_st <= IDLE;
         else if (rx_st == IDLE) begin
            if (rx_prev && !rx_in) begin
               rx_st <= START;
               rx_cnt <= 4'd8;
            end
         end else if (tick) begin
            rx_cnt <= rx_cnt + 4'd1;
            if (rx_cnt == 4'd15) begin
               case (rx_st)
                  START: begin
                     rx_st <= rx_in ? IDLE : DATA;
                     rx_idx <= 3'd0;
                  end
                  DATA: begin
                     rx_sh <= {rx_in, rx_sh[DATA_BITS-1:1]};
                     rx_idx <= rx_idx + 3'd1;
`ifdef UART_PARITY_EN
                     if (rx_idx == 3'(DATA_BITS - 1)) rx_st <= ctrl[3] ? PARITY : STOP;
`else
                     if (rx_idx == 3'(DATA_BITS - 1)) rx_st <= STOP;
`endif
                  end
`ifdef UART_PARITY_EN
                  PARITY: begin
                     rx_par <= rx_in;
                     rx_st <= STOP;
                  end
`endif
                  STOP: begin
                     rx_st <= IDLE;
                     rx_push <= 1'b1;
                     rx_ferr <= ~rx_in;
`ifdef UART_PARITY_EN
                     rx_perr <= ctrl[3] & (rx_par != (^rx_sh ^ ctrl[2]));
`endif
                  end
                  default: rx_st <= IDLE;
               endcase
            end
         end
      end
   end
endmodule

// File: tb/tb_ahb_uart_pro.sv
// tb_ahb_uart_pro: directed scoreboard bench for ahb_uart_pro (bus reads and pin probes)
module tb_ahb_uart_pro;
   logic clk = 1'b0, rst = 1'b1, rs_rx = 1'b1;
   logic rs_tx, irq;
   logic rd_dphase = 1'b0, probe_req = 1'b0;
   int n_tests = 0, n_fail = 0;
   typedef struct {
      string name;
      logic [31:0] exp;
      logic [31:0] mask;
      int kind;
   } item_t;
   item_t q[$];
   always #5 clk = ~clk;
   ahb_uart_pro_if bus();
   ahb_uart_pro dut (.HCLK(clk), .HRESET(rst), .bus(bus), .RsRx(rs_rx), .RsTx(rs_tx), .uart_irq(irq));
   // Monitor: pops one expectation per read data phase or pin probe
   always @(negedge clk) begin
      item_t it;
      logic [31:0] act;
      if (rd_dphase || probe_req) begin
         n_tests++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got output, want queued expectation");
         end else begin
            it = q.pop_front();
            act = it.kind == 0 ? bus.HRDATA : it.kind == 1 ? {31'd0, rs_tx} : {31'd0, irq};
            if ((act & it.mask) !== (it.exp & it.mask)) begin
               n_fail++;
               $display("FAIL %s: got %08h want %08h", it.name, act & it.mask, it.exp & it.mask);
            end
         end
      end
   end
   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      @(posedge clk); #1;
      bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = addr;
      @(posedge clk); #1;
      bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWDATA = data;
   endtask
   task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input logic [31:0] mask, input string name);
      @(posedge clk); #1;
      bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0; bus.HADDR = addr;
      q.push_back('{name, exp, mask, 0});
      @(posedge clk); #1;
      bus.HSEL = 1'b0; bus.HTRANS = 2'b00; rd_dphase = 1'b1;
      @(negedge clk); #1;
      rd_dphase = 1'b0;
   endtask
   task automatic probe(input int kind, input logic [31:0] exp, input string name);
      q.push_back('{name, exp, 32'hFFFF_FFFF, kind});
      probe_req = 1'b1;
      @(negedge clk); #1;
      probe_req = 1'b0;
   endtask
   task automatic sbit(input logic b);
      rs_rx = b;
      repeat (16) @(posedge clk);
      #1;
   endtask
   task automatic send(input logic [7:0] d, input bit pen, input bit pb, input bit stop);
      @(posedge clk); #1;
      sbit(1'b0);
      for (int i = 0; i < 8; i++) sbit(d[i]);
      if (pen) sbit(pb);
      sbit(stop);
      sbit(1'b1);
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end
   initial begin
      bus.HSEL = 1'b0; bus.HADDR = '0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HREADY = 1'b1; bus.HWDATA = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      probe(0, 32'd0, "reset_hrdata");
      probe(1, 32'd1, "reset_rstx");
      probe(2, 32'd0, "reset_irq");
      rd(32'h04, 32'h0000_0005, 32'hFFFF_FFFF, "reset_status");
      rd(32'h08, 32'd0, 32'hFFFF_FFFF, "reset_ctrl");
      rd(32'h0C, 32'd325, 32'hFFFF_FFFF, "reset_bauddiv");
      rd(32'h10, 32'd0, 32'hFFFF_FFFF, "reset_irq_en");
      // loopback round trip at the fastest divisor
      wr(32'h0C, 32'd0);
      wr(32'h08, 32'h13);
      wr(32'h00, 32'hA5);
      repeat (80) @(posedge clk);
      probe(1, 32'd1, "loopback_rstx_held");
      repeat (84) @(posedge clk);
      rd(32'h04, 32'd0, 32'h1, "loopback_rx_not_empty");
      rd(32'h00, 32'hA5, 32'hFFFF_FFFF, "loopback_data");
      rd(32'h04, 32'd1, 32'h1, "loopback_rx_empty_again");
      // TX FIFO overflow with the transmitter disabled
      wr(32'h08, 32'h00);
      for (int i = 0; i < 17; i++) wr(32'h00, 32'(i));
      rd(32'h04, 32'h1000_0108, 32'hFF00_010C, "tx_fill_status");
      wr(32'h04, 32'h100);
      rd(32'h04, 32'h1000_0008, 32'hFF00_010C, "tx_ovf_cleared");
      // framing error, byte still stored, sticky interrupt
      wr(32'h08, 32'h02);
      send(8'h3C, 1'b0, 1'b0, 1'b0);
      rd(32'h04, 32'h0000_0040, 32'h0000_00E1, "frame_err_status");
      rd(32'h00, 32'h3C, 32'hFFFF_FFFF, "frame_err_data");
      wr(32'h10, 32'h4);
      repeat (2) @(posedge clk);
      probe(2, 32'd1, "irq_sticky");
      wr(32'h04, 32'h1E0);
      repeat (2) @(posedge clk);
      probe(2, 32'd0, "irq_cleared");
      wr(32'h10, 32'h0);
`ifdef UART_PARITY_EN
      wr(32'h08, 32'h0E);
      rd(32'h08, 32'h0E, 32'hFFFF_FFFF, "ctrl_parity_rw");
      send(8'h01, 1'b1, 1'b1, 1'b1);
      rd(32'h04, 32'h80, 32'hE1, "parity_err_set");
      rd(32'h00, 32'h01, 32'hFFFF_FFFF, "parity_bad_data");
      wr(32'h04, 32'h1E0);
      send(8'h01, 1'b1, 1'b0, 1'b1);
      rd(32'h04, 32'h00, 32'hE1, "parity_ok_status");
      rd(32'h00, 32'h01, 32'hFFFF_FFFF, "parity_ok_data");
`else
      wr(32'h08, 32'h0E);
      rd(32'h08, 32'h02, 32'hFFFF_FFFF, "ctrl_parity_masked");
      send(8'h01, 1'b0, 1'b0, 1'b1);
      rd(32'h04, 32'h00, 32'hE1, "no_parity_status");
      rd(32'h00, 32'h01, 32'hFFFF_FFFF, "no_parity_data");
`endif
      // RX FIFO overrun and in-order drain
      wr(32'h08, 32'h02);
      for (int i = 0; i < 17; i++) send(8'(8'h10 + i), 1'b0, 1'b0, 1'b1);
      rd(32'h04, 32'h0010_0022, 32'h00FF_00E3, "rx_full_status");
      for (int i = 0; i < 16; i++) rd(32'h00, 32'h10 + 32'(i), 32'hFFFF_FFFF, $sformatf("rx_order_%0d", i));
      rd(32'h04, 32'h0000_0001, 32'h00FF_0003, "rx_drained");
      // transmit start, then asynchronous reset mid-frame
      wr(32'h08, 32'h01);
      repeat (4) @(posedge clk);
      probe(1, 32'd0, "tx_start_bit");
      #2 rst = 1'b1;
      probe(1, 32'd1, "async_reset_rstx");
      @(posedge clk); #1 rst = 1'b0;
      rd(32'h04, 32'h0000_0005, 32'hFFFF_FFFF, "post_reset_status");
      repeat (3) @(posedge clk);
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
